// File: rtl/vec_issue_pkg.sv
// -----------------------------------------------------------------------------
// vec_issue_pkg
// Shared types for the vector issue controller.
//   VEC_XLEN      : default instruction/operand width; issue_entry_t is built
//                   from it, so vec_issue_ctrl's XLEN must equal it.
//   issue_state_e : issue FSM states (IDLE / ISSUE / WAIT).
//   issue_entry_t : one queued instruction with its two scalar operands.
// -----------------------------------------------------------------------------
package vec_issue_pkg;

  localparam int VEC_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [VEC_XLEN-1:0] inst;
    logic [VEC_XLEN-1:0] rs1;
    logic [VEC_XLEN-1:0] rs2;
  } issue_entry_t;

endpackage

// File: rtl/vec_issue_fifo.sv
// -----------------------------------------------------------------------------
// vec_issue_fifo
// Synchronous FIFO with flush. The head word is visible on pop_data whenever
// the FIFO is non-empty (show-ahead). DEPTH must be a power of two, so the
// pointers wrap naturally.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   push        : write push_data (ignored when full or when flush is high)
//   pop         : advance the head (ignored when empty)
//   flush       : empty the FIFO at the next edge; wins over a same-cycle push
//   count       : occupancy, 0..DEPTH
//   full, empty : occupancy flags, derived from registered count only
// -----------------------------------------------------------------------------
module vec_issue_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define which
  // words are valid, and leaving the array out of reset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vec_issue_ctrl.sv
// -----------------------------------------------------------------------------
// vec_issue_ctrl
// Queues vector instructions (with rs1/rs2 values) from the scalar core and
// issues them one at a time to the non-pipelined vector datapath. An issued
// instruction stays in flight until vec_done.
// Configuration macro:
//   VEC_ISSUE_BYPASS_EN : a push arriving in IDLE with an empty queue loads the
//                         issue register directly (1-cycle latency) and never
//                         touches the queue. Undefined: all pushes are queued.
// Ports:
//   clk, reset                      : clock, asynchronous active-low reset
//   scl_valid/scl_ready             : scalar-side handshake (ready = not full)
//   scl_inst/rs1_data/rs2_data      : instruction and operand values
//   vec_valid/vec_ready             : datapath-side handshake
//   vec_inst/rs1_data/rs2_data      : issue register contents (flop outputs)
//   vec_done                        : completion pulse for the in-flight inst
//   flush                           : drop all queued, not-yet-issued entries
//   busy                            : FSM not IDLE or queue non-empty
//   q_count                         : queue occupancy
// -----------------------------------------------------------------------------
module vec_issue_ctrl
  import vec_issue_pkg::*;
#(
  parameter int XLEN   = VEC_XLEN,
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      scl_valid,
  output logic                      scl_ready,
  input  logic [XLEN-1:0]           scl_inst,
  input  logic [XLEN-1:0]           scl_rs1_data,
  input  logic [XLEN-1:0]           scl_rs2_data,
  output logic                      vec_valid,
  input  logic                      vec_ready,
  output logic [XLEN-1:0]           vec_inst,
  output logic [XLEN-1:0]           vec_rs1_data,
  output logic [XLEN-1:0]           vec_rs2_data,
  input  logic                      vec_done,
  input  logic                      flush,
  output logic                      busy,
  output logic [$clog2(QDEPTH):0]   q_count
);

  issue_state_e state;
  issue_entry_t issue_q;
  issue_entry_t push_entry;
  issue_entry_t head_entry;
  logic         q_full;
  logic         q_empty;
  logic         push_acc;
  logic         fifo_push;
  logic         pop;
  logic         bypass;

  assign push_entry = '{inst: scl_inst, rs1: scl_rs1_data, rs2: scl_rs2_data};

  assign scl_ready = !q_full;
  assign push_acc  = scl_valid && scl_ready;

`ifdef VEC_ISSUE_BYPASS_EN
  // A flushed push is dropped, so it must not slip through the bypass either.
  assign bypass = push_acc && !flush && (state == IDLE) && q_empty;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = push_acc && !bypass;

  // The head leaves the queue whenever the issue register is free: in IDLE,
  // or in WAIT on the completion pulse (back-to-back issue).
  assign pop  = !q_empty && ((state == IDLE) || ((state == WAIT) && vec_done));
  assign busy = (state != IDLE) || !q_empty;

  vec_issue_fifo #(
    .WIDTH ($bits(issue_entry_t)),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .flush     (flush),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // NOTE: state, vec_valid and the issue register are updated together with
  // non-blocking assignments so every branch sees the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      vec_valid <= 1'b0;
      issue_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            issue_q   <= head_entry;
            vec_valid <= 1'b1;
            state     <= ISSUE;
          end else if (bypass) begin
            issue_q   <= push_entry;
            vec_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Issue register holds steady until the datapath accepts it.
          if (vec_ready) begin
            vec_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (vec_done) begin
            if (pop) begin
              issue_q   <= head_entry;
              vec_valid <= 1'b1;
              state     <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          vec_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign vec_inst     = issue_q.inst;
  assign vec_rs1_data = issue_q.rs1;
  assign vec_rs2_data = issue_q.rs2;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vec_issue_ctrl
// Self-checking bench for vec_issue_ctrl. A queue-based reference model tracks
// the pending instructions and the single in-flight slot; a compare process
// checks every DUT output against it on each falling edge. Directed scenarios
// add literal expectations. Honours VEC_ISSUE_BYPASS_EN when defined.
// -----------------------------------------------------------------------------
module tb_vec_issue_ctrl;

  localparam int XLEN   = 32;
  localparam int QDEPTH = 4;
`ifdef VEC_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            scl_valid = 1'b0;
  logic            scl_ready;
  logic [XLEN-1:0] scl_inst = '0;
  logic [XLEN-1:0] scl_rs1_data = '0;
  logic [XLEN-1:0] scl_rs2_data = '0;
  logic            vec_valid;
  logic            vec_ready = 1'b0;
  logic [XLEN-1:0] vec_inst;
  logic [XLEN-1:0] vec_rs1_data;
  logic [XLEN-1:0] vec_rs2_data;
  logic            vec_done = 1'b0;
  logic            flush = 1'b0;
  logic            busy;
  logic [2:0]      q_count;

  vec_issue_ctrl #(.XLEN(XLEN), .QDEPTH(QDEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .scl_valid    (scl_valid),
    .scl_ready    (scl_ready),
    .scl_inst     (scl_inst),
    .scl_rs1_data (scl_rs1_data),
    .scl_rs2_data (scl_rs2_data),
    .vec_valid    (vec_valid),
    .vec_ready    (vec_ready),
    .vec_inst     (vec_inst),
    .vec_rs1_data (vec_rs1_data),
    .vec_rs2_data (vec_rs2_data),
    .vec_done     (vec_done),
    .flush        (flush),
    .busy         (busy),
    .q_count      (q_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } ent_t;

  ent_t mq[$];        // instructions waiting to be issued, oldest first
  ent_t slot;         // instruction owned by the datapath side
  bit   slot_valid = 1'b0;
  bit   slot_sent  = 1'b0;  // handshake done, awaiting completion
  bit   m_push;
  bit   m_byp;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      slot_valid = 1'b0;
      slot_sent  = 1'b0;
    end else begin
      m_push = scl_valid && (mq.size() != QDEPTH);
      m_byp  = 1'b0;
      if (!slot_valid) begin
        if (mq.size() > 0) begin
          slot = mq.pop_front();
          slot_valid = 1'b1;
          slot_sent  = 1'b0;
        end else if (BYP && m_push && !flush) begin
          slot = '{scl_inst, scl_rs1_data, scl_rs2_data};
          slot_valid = 1'b1;
          slot_sent  = 1'b0;
          m_byp = 1'b1;
        end
      end else if (!slot_sent) begin
        if (vec_ready) slot_sent = 1'b1;
      end else if (vec_done) begin
        if (mq.size() > 0) begin
          slot = mq.pop_front();
          slot_sent = 1'b0;
        end else begin
          slot_valid = 1'b0;
        end
      end
      if (flush) mq.delete();
      else if (m_push && !m_byp) mq.push_back('{scl_inst, scl_rs1_data, scl_rs2_data});
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("m_vec_valid", vec_valid, slot_valid && !slot_sent);
      check("m_scl_ready", scl_ready, mq.size() != QDEPTH);
      check("m_q_count",   q_count,   mq.size());
      check("m_busy",      busy,      slot_valid || (mq.size() != 0));
      if (slot_valid && !slot_sent) begin
        check("m_vec_inst", vec_inst,     slot.inst);
        check("m_vec_rs1",  vec_rs1_data, slot.rs1);
        check("m_vec_rs2",  vec_rs2_data, slot.rs2);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    scl_valid    = 1'b1;
    scl_inst     = i;
    scl_rs1_data = a;
    scl_rs2_data = b;
  endtask

  task automatic handshake_and_done();
    vec_ready = 1'b1; step(); vec_ready = 1'b0;
    vec_done  = 1'b1; step(); vec_done  = 1'b0;
  endtask

  logic [31:0] d_inst [6];

  initial begin
    for (int i = 0; i < 6; i++) d_inst[i] = 32'hA000_0000 + 32'(i);

    // Reset values
    #12;
    check("rst_vec_valid", vec_valid, 1'b0);
    check("rst_vec_inst",  vec_inst,  32'h0);
    check("rst_busy",      busy,      1'b0);
    check("rst_q_count",   q_count,   3'd0);
    check("rst_scl_ready", scl_ready, 1'b1);
    @(posedge clk); #3 reset = 1'b1;

    // Single instruction: latency, fields, WAIT, completion
    step();
    offer(32'h0020_8057, 32'd16, 32'd0);
    step(); scl_valid = 1'b0;
    check("t1_valid_after_1", vec_valid, BYP);
    check("t1_qcount_after_1", q_count, BYP ? 3'd0 : 3'd1);
    step();
    check("t1_valid_after_2", vec_valid, 1'b1);
    check("t1_inst", vec_inst, 32'h0020_8057);
    check("t1_rs1",  vec_rs1_data, 32'd16);
    check("t1_rs2",  vec_rs2_data, 32'd0);
    vec_ready = 1'b1; step(); vec_ready = 1'b0;
    check("t1_wait_valid", vec_valid, 1'b0);
    check("t1_wait_busy",  busy, 1'b1);
    vec_done = 1'b1; step(); vec_done = 1'b0;
    check("t1_idle_busy",  busy, 1'b0);

    // Five pushes with the datapath stalled, plus one rejected while full
    for (int i = 0; i < 6; i++) begin
      offer(d_inst[i], 32'(i * 3), 32'(i * 7));
      step();
    end
    scl_valid = 1'b0;
    check("t2_q_full_count", q_count, 3'd4);
    check("t2_scl_ready",    scl_ready, 1'b0);
    check("t2_head_inst",    vec_inst, d_inst[0]);
    for (int i = 0; i < 5; i++) begin
      vec_ready = 1'b1; step(); vec_ready = 1'b0;
      check("t2_wait_valid", vec_valid, 1'b0);
      vec_done = 1'b1; step(); vec_done = 1'b0;
      if (i < 4) begin
        check("t2_next_valid", vec_valid, 1'b1);
        check("t2_next_inst",  vec_inst, d_inst[i+1]);
        check("t2_next_count", q_count, 32'(3 - i));
      end else begin
        check("t2_drained_busy", busy, 1'b0);
      end
    end

    // Stall in ISSUE for 10 cycles; a vec_done there is ignored
    offer(32'h1234_5678, 32'h11, 32'h22);
    step(); scl_valid = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_hold_inst",  vec_inst, 32'h1234_5678);
      check("t3_hold_valid", vec_valid, 1'b1);
    end
    vec_done = 1'b1; step(); vec_done = 1'b0;
    check("t3_done_ignored", vec_valid, 1'b1);
    handshake_and_done();
    check("t3_end_busy", busy, 1'b0);

    // Flush with a same-cycle push while WAIT holds an instruction
    offer(32'hBEEF_0001, 32'h1, 32'h2);
    step(); scl_valid = 1'b0;
    step();
    vec_ready = 1'b1; step(); vec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'hC000_0000 + 32'(i), 32'h0, 32'h0);
      step();
    end
    check("t4_queued", q_count, 3'd3);
    offer(32'hDEAD_DEAD, 32'h0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0; scl_valid = 1'b0;
    check("t4_flushed_count", q_count, 3'd0);
    check("t4_inflight_busy", busy, 1'b1);
    vec_done = 1'b1; step(); vec_done = 1'b0;
    check("t4_idle_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_no_issue", vec_valid, 1'b0);
    end

    // Reset mid-operation: WAIT with two queued
    offer(32'h5555_0000, 32'h5, 32'h6);
    step(); scl_valid = 1'b0;
    step();
    vec_ready = 1'b1; step(); vec_ready = 1'b0;
    offer(32'h5555_0001, 32'h0, 32'h0); step();
    offer(32'h5555_0002, 32'h0, 32'h0); step();
    scl_valid = 1'b0;
    check("t5_pre_count", q_count, 3'd2);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_valid", vec_valid, 1'b0);
    check("t5_rst_inst",  vec_inst,  32'h0);
    check("t5_rst_rs1",   vec_rs1_data, 32'h0);
    check("t5_rst_busy",  busy, 1'b0);
    check("t5_rst_count", q_count, 3'd0);
    check("t5_rst_ready", scl_ready, 1'b1);
    @(posedge clk); #3 reset = 1'b1;
    step();
    offer(32'h7777_0007, 32'h70, 32'h71);
    step(); scl_valid = 1'b0;
    check("t5_post_valid_1", vec_valid, BYP);
    step();
    check("t5_post_valid_2", vec_valid, 1'b1);
    check("t5_post_inst",    vec_inst, 32'h7777_0007);
    handshake_and_done();
    check("t5_post_busy", busy, 1'b0);

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
